uart_tx_scheduler: RTL
======================

Name: uart_tx_scheduler

Overview:
- Shares one UART transmit channel between NUM_REQ byte-stream requesters, for example the command response path, debug log and status beacon.
- Uses round-robin arbitration with packet lock: a granted requester keeps the channel until it transfers a byte flagged last.
- Inserts a configurable idle gap between packets.
- Breaks a stalled grant after a timeout.
- Sits directly in front of the UART transmitter's byte-load interface.

Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- GAP_CYCLES, 16: idle clk cycles forced between packets; 0 means no gap.
- TIMEOUT_CYCLES, 1024: consecutive cycles the granted requester may hold req_valid low mid-packet before its grant is revoked; 0 disables the timeout.

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-high
- req_valid  input  NUM_REQ  per-requester byte valid
- req_data  input  8*NUM_REQ  per-requester byte; requester i uses bits [8i+7:8i]
- req_last  input  NUM_REQ  per-requester end-of-packet flag, qualified by req_valid
- req_ready  output  NUM_REQ  per-requester byte accepted
- tx_data  output  8  byte to the UART transmitter
- tx_valid  output  1  tx_data valid
- tx_ready  input  1  transmitter can accept a byte this cycle
- grant  output  NUM_REQ  one-hot current owner; all zero when not in XFER
- busy  output  1  state is not IDLE
- pkt_done  output  1  one-cycle pulse when a last byte is accepted
- timeout_err  output  1  one-cycle pulse when a grant is revoked by timeout

Behaviour:
- Reset (async): state=IDLE, grant=0, last_owner=NUM_REQ-1 (requester 0 wins first), gap and timeout counters=0.
- Reset outputs: req_ready=0, tx_valid=0, tx_data=0, busy=0, pkt_done=0, timeout_err=0.
- A reset mid-packet discards the packet silently; no pulse is produced.
- States: IDLE, XFER, GAP.
- IDLE:
  - If any req_valid is high, on the next edge enter XFER.
  - Register grant to the first requester with req_valid set, searching upward from last_owner+1 with wrap.
  - Set last_owner to that index.
  - Clear the timeout counter.
- XFER:
  - Datapath is combinational from the granted requester: tx_data=req_data[grant]; tx_valid=req_valid[grant].
  - req_ready[i] = grant[i] & tx_ready. Non-granted requesters see req_ready=0.
  - tx_data is 0 whenever tx_valid=0.
  - A transfer occurs when tx_valid & tx_ready; it clears the timeout counter.
  - A transfer with req_last[grant]=1 pulses pkt_done in that same cycle. Next state is GAP if GAP_CYCLES>0, else IDLE. grant clears at the edge.
  - A cycle with req_valid[grant]=0 increments the timeout counter (saturating).
  - When TIMEOUT_CYCLES>0 and the counter reaches TIMEOUT_CYCLES-1 while req_valid[grant] is still low: pulse timeout_err in that cycle, then leave XFER exactly as for a last byte.
  - If transfer and timeout would coincide, the transfer wins: it requires valid, so the timeout cannot fire.
  - req_valid on other requesters during XFER is ignored and has no effect on grant.
- GAP:
  - Load the gap counter with GAP_CYCLES-1 on entry; decrement each cycle; leave to IDLE when it reaches 0.
  - Total GAP occupancy is exactly GAP_CYCLES cycles.
  - Outputs during GAP: tx_valid=0, req_ready=0, grant=0.
- Latency and throughput:
  - From IDLE, the first byte can be offered to the transmitter one cycle after req_valid rises.
  - Back-to-back bytes within a packet are accepted every cycle tx_ready=1.
- Fairness: after owner k finishes, requester k is lowest priority; all requesters continuously valid are served in order k+1, k+2, … with wrap.
- Only req_valid of the granted index is sampled; X on non-granted lanes must not propagate to tx_data.
- Counter width: clog2(max(TIMEOUT_CYCLES, GAP_CYCLES, 2)) bits.

Test Plan:
- Single requester 1 sends 3-byte packet 0xA1,0xA2,0xA3 (last on 0xA3), tx_ready=1 -> grant=0010 one cycle after req_valid; tx_data sequence A1,A2,A3 on consecutive cycles; pkt_done pulses with A3; busy low exactly GAP_CYCLES=16 cycles later.
- All 4 requesters continuously valid with 1-byte packets, GAP_CYCLES=0 -> grant order 0,1,2,3,0 after reset; no requester granted twice before all others are served.
- Requester 2 mid-packet while requester 0 raises valid; tx_ready toggles 1,0,1 -> requester 0 is not granted until requester 2's last byte is accepted; req_ready[2] follows tx_ready exactly; byte stalled under tx_ready=0 is not duplicated or lost.
- Granted requester 3 drops req_valid after first byte, TIMEOUT_CYCLES=8 -> timeout_err pulses on the 8th idle cycle; pkt_done stays 0; GAP entered, then a pending requester 0 is granted.
- Reset asserted mid-packet in XFER -> all outputs 0 immediately (async); after release, requester 0 is first-priority; no stale pkt_done or timeout_err pulse.
- GAP_CYCLES=0 and TIMEOUT_CYCLES=0, a requester holds valid low for 5000 cycles mid-packet -> grant is held, no timeout_err; after the last byte the next IDLE arbitration occurs on the following cycle.

Source files
------------

// File: rtl/uart_tx_scheduler.sv
// Round-robin, packet-locked scheduler sharing one UART transmit byte interface
// between NUM_REQ requesters, with an inter-packet idle gap and a stall timeout.
module uart_tx_scheduler #(
  parameter int NUM_REQ        = 4,
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [8*NUM_REQ-1:0]   req_data,
  input  logic [NUM_REQ-1:0]     req_last,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [7:0]             tx_data,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  output logic [NUM_REQ-1:0]     grant,
  output logic                   busy,
  output logic                   pkt_done,
  output logic                   timeout_err
);

  localparam int CNT_MAX = (TIMEOUT_CYCLES > GAP_CYCLES)
                         ? ((TIMEOUT_CYCLES > 2) ? TIMEOUT_CYCLES : 2)
                         : ((GAP_CYCLES > 2) ? GAP_CYCLES : 2);
  localparam int CW = $clog2(CNT_MAX);
  localparam int IW = $clog2(NUM_REQ);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_XFER = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  localparam logic [CW-1:0] GAP_LOAD  = (GAP_CYCLES > 0) ? CW'(GAP_CYCLES - 1) : '0;
  localparam logic [CW-1:0] TO_LAST   = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [IW-1:0] LAST_INIT = IW'(NUM_REQ - 1);

  logic [1:0]         state;
  logic [NUM_REQ-1:0] grant_q;
  logic [IW-1:0]      last_owner;
  logic [CW-1:0]      gap_cnt;
  logic [CW-1:0]      to_cnt;

  logic [NUM_REQ-1:0] arb_onehot;
  logic [IW-1:0]      arb_idx;
  logic [IW-1:0]      cand;
  logic               arb_found;
  logic               lane_valid;
  logic               lane_last;
  logic [7:0]         lane_data;
  logic               xfer;
  logic               to_fire;
  logic               pkt_end;

  // Search starts just above the previous owner so it becomes lowest priority.
  always_comb begin
    arb_onehot = '0;
    arb_idx    = last_owner;
    arb_found  = 1'b0;
    cand       = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = IW'((32'(last_owner) + k) % NUM_REQ);
      if (!arb_found && req_valid[cand]) begin
        arb_found        = 1'b1;
        arb_idx          = cand;
        arb_onehot[cand] = 1'b1;
      end
    end
  end

  // Only the granted lane is looked at, so unknowns elsewhere cannot leak out.
  always_comb begin
    lane_valid = 1'b0;
    lane_last  = 1'b0;
    lane_data  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) begin
        lane_valid = req_valid[i];
        lane_last  = req_last[i];
        lane_data  = req_data[8*i +: 8];
      end
    end
  end

  assign tx_valid    = lane_valid;
  assign tx_data     = lane_valid ? lane_data : '0;
  assign req_ready   = grant_q & {NUM_REQ{tx_ready}};
  assign xfer        = lane_valid & tx_ready;
  assign pkt_done    = xfer & lane_last;
  assign to_fire     = (TIMEOUT_CYCLES > 0) && (state == S_XFER) && !lane_valid
                       && (to_cnt == TO_LAST);
  assign pkt_end     = pkt_done | to_fire;
  assign timeout_err = to_fire;
  assign grant       = grant_q;
  assign busy        = (state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      grant_q    <= '0;
      last_owner <= LAST_INIT;
      gap_cnt    <= '0;
      to_cnt     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (arb_found) begin
            state      <= S_XFER;
            grant_q    <= arb_onehot;
            last_owner <= arb_idx;
            to_cnt     <= '0;
          end
        end
        S_XFER: begin
          if (pkt_end) begin
            grant_q <= '0;
            to_cnt  <= '0;
            if (GAP_CYCLES > 0) begin
              state   <= S_GAP;
              gap_cnt <= GAP_LOAD;
            end else begin
              state <= S_IDLE;
            end
          end else if (lane_valid) begin
            to_cnt <= '0;
          end else if (to_cnt != '1) begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        S_GAP: begin
          if (gap_cnt == '0) state <= S_IDLE;
          else               gap_cnt <= gap_cnt - 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
